file_pos_tracker: RTL and testbench

FILE_POS_TRACKER -- requirements
Module: file_pos_tracker

---
 rtl/file_pos_tracker.sv | 127 ++++++++++++
 tb/tb_file_pos_tracker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/file_pos_tracker.sv
// file_pos_tracker: file position/size/eof tracker with seek requests; define FILE_POS_CLAMP_EN to clamp out-of-range seeks
module file_pos_tracker #(
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [POS_W-1:0] req_offset,
    input  logic             xfer_valid,
    input  logic             xfer_write,
    input  logic             size_load,
    input  logic [POS_W-1:0] size_in,
    output logic             rsp_valid,
    output logic [31:0]      rsp_code,
    output logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] size,
    output logic             eof
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    localparam logic [1:0] OP_CUR = 2'd1;
    localparam logic [1:0] OP_END = 2'd2;
    localparam logic [1:0] OP_REW = 2'd3;
    localparam int TW = POS_W + 2;
    localparam logic [POS_W-1:0] ONE = POS_W'(1);

    state_t state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [POS_W-1:0] off_q, off_d, pos_q, pos_d, size_q, size_d;
    logic [TW-1:0] tgt_q, tgt_d, base, off_ext;
    logic eof_q, eof_d, rsp_valid_q, rsp_valid_d, accept, in_range;
    logic [31:0] rsp_code_q, rsp_code_d;

    assign req_ready = state_q == IDLE;
    assign accept    = req_valid && req_ready;
    assign base      = op_q == OP_CUR ? {2'b00, pos_q} : op_q == OP_END ? {2'b00, size_q} : '0;
    assign off_ext   = {{2{off_q[POS_W-1]}}, off_q};
    // target is a POS_W+2 signed value: sign bit set means below zero
    assign in_range  = !tgt_q[TW-1] && tgt_q <= {2'b00, size_q};
    assign rsp_valid = rsp_valid_q;
    assign rsp_code  = rsp_code_q;
    assign pos       = pos_q;
    assign size      = size_q;
    assign eof       = eof_q;

    // next-state: request sequencing in CALC/RESP, transfers and size loads only in an idle cycle with no acceptance
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        tgt_d       = tgt_q;
        pos_d       = pos_q;
        size_d      = size_q;
        eof_d       = eof_q;
        rsp_valid_d = 1'b0;
        rsp_code_d  = rsp_code_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    op_d    = req_op;
                    off_d   = req_offset;
                end else if (size_load) begin
                    size_d = size_in;
                    pos_d  = pos_q < size_in ? pos_q : size_in;
                    eof_d  = 1'b0;
                end else if (xfer_valid && xfer_write) begin
                    if (pos_q != '1) begin
                        pos_d  = pos_q + ONE;
                        size_d = pos_q == size_q ? size_q + ONE : size_q;
                    end
                end else if (xfer_valid) begin
                    pos_d = pos_q < size_q ? pos_q + ONE : pos_q;
                    eof_d = pos_q < size_q ? eof_q : 1'b1;
                end
            end
            CALC: begin
                state_d = RESP;
                tgt_d   = op_q == OP_REW ? '0 : base + off_ext;
            end
            RESP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                if (in_range) begin
                    pos_d      = tgt_q[POS_W-1:0];
                    eof_d      = 1'b0;
                    rsp_code_d = '0;
                end else begin
`ifdef FILE_POS_CLAMP_EN
                    pos_d      = tgt_q[TW-1] ? '0 : size_q;
                    eof_d      = 1'b0;
                    rsp_code_d = '0;
`else
                    rsp_code_d = '1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            off_q       <= '0;
            tgt_q       <= '0;
            pos_q       <= '0;
            size_q      <= '0;
            eof_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            tgt_q       <= tgt_d;
            pos_q       <= pos_d;
            size_q      <= size_d;
            eof_q       <= eof_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_code_q  <= rsp_code_d;
        end
    end
endmodule

// File: tb/tb_file_pos_tracker.sv
// tb_file_pos_tracker: scoreboard-based bench for file_pos_tracker (POS_W=16)
module tb_file_pos_tracker;
    logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, xfer_valid = 1'b0, xfer_write = 1'b0, size_load = 1'b0;
    logic [1:0] req_op = 2'd0;
    logic [15:0] req_offset = 16'd0, size_in = 16'd0;
    logic req_ready, rsp_valid, eof;
    logic [31:0] rsp_code;
    logic [15:0] pos, size;
    int checks = 0, errors = 0;

`ifdef FILE_POS_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;
    localparam logic [1:0] SET = 2'd0, CUR = 2'd1, ENDP = 2'd2, REW = 2'd3;

    typedef struct {
        logic [31:0] code;
        logic [15:0] pos;
        logic        eof;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    logic got_rsp, got_eof, got_ready;
    logic [31:0] got_code;
    logic [15:0] got_pos;
    int lat, ready_low;

    always #5 clk = ~clk;

    file_pos_tracker #(.POS_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_offset(req_offset), .xfer_valid(xfer_valid),
        .xfer_write(xfer_write), .size_load(size_load), .size_in(size_in),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code), .pos(pos), .size(size), .eof(eof)
    );

    // drive one request (optionally with a colliding read held through the request), scramble inputs after acceptance, wait for the response
    task automatic send_req(input logic [1:0] op, input logic [15:0] off, input logic wx);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_offset = off; xfer_valid = wx; xfer_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; req_op = ~op; req_offset = ~off;
        got_rsp = 1'b0; lat = 1; ready_low = 0;
        for (int i = 0; i < 8 && !got_rsp; i++) begin
            if (rsp_valid) begin
                got_rsp = 1'b1; got_code = rsp_code; got_pos = pos; got_eof = eof; got_ready = req_ready;
                xfer_valid = 1'b0;
            end else begin
                if (!req_ready) ready_low++;
                lat++;
                @(negedge clk);
            end
        end
        xfer_valid = 1'b0;
    endtask

    task automatic pulse(input logic xv, input logic xw, input logic sl, input logic [15:0] sz);
        @(negedge clk);
        xfer_valid = xv; xfer_write = xw; size_load = sl; size_in = sz;
        @(negedge clk);
        xfer_valid = 1'b0; size_load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (pos !== 16'd0 || size !== 16'd0 || eof !== 1'b0 || rsp_valid !== 1'b0 || rsp_code !== 32'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: pos=%0d size=%0d eof=%b rsp_valid=%b code=%h ready=%b, want 0 0 0 0 0 1", pos, size, eof, rsp_valid, rsp_code, req_ready);
        end
    endtask

    task automatic test_set();
        pulse(1'b0, 1'b0, 1'b1, 16'd100);
        checks++;
        if (size !== 16'd100 || pos !== 16'd0) begin
            errors++; $display("FAIL size_load100: size=%0d pos=%0d, want 100 0", size, pos);
        end
        sb.push_back('{32'd0, 16'd40, 1'b0});
        send_req(SET, 16'd40, 1'b0);
        e = sb.pop_front(); checks++;
        if (!got_rsp || got_code !== e.code || got_pos !== e.pos || got_eof !== e.eof || lat !== 3 || ready_low !== 2 || got_ready !== 1'b1) begin
            errors++; $display("FAIL set40: rsp=%b code=%h pos=%0d eof=%b lat=%0d rdy_low=%0d, want rsp=1 code=%h pos=%0d eof=%b lat=3 rdy_low=2", got_rsp, got_code, got_pos, got_eof, lat, ready_low, e.code, e.pos, e.eof);
        end
    endtask

    task automatic test_out_of_range();
        sb.push_back('{CLAMP ? 32'd0 : ERR, CLAMP ? 16'd0 : 16'd40, 1'b0});
        send_req(CUR, 16'hFFCE, 1'b0);
        e = sb.pop_front(); checks++;
        if (!got_rsp || got_code !== e.code || got_pos !== e.pos || got_eof !== e.eof || lat !== 3) begin
            errors++; $display("FAIL cur_minus50: rsp=%b code=%h pos=%0d eof=%b lat=%0d, want code=%h pos=%0d eof=%b lat=3", got_rsp, got_code, got_pos, got_eof, lat, e.code, e.pos, e.eof);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_code !== e.code) begin
            errors++; $display("FAIL code_hold: rsp_valid=%b code=%h, want 0 %h", rsp_valid, rsp_code, e.code);
        end
        sb.push_back('{32'd0, 16'd100, 1'b0});
        send_req(SET, 16'd100, 1'b0);
        e = sb.pop_front(); checks++;
        if (!got_rsp || got_code !== e.code || got_pos !== e.pos || got_eof !== e.eof) begin
            errors++; $display("FAIL set_eq_size: rsp=%b code=%h pos=%0d eof=%b, want code=%h pos=%0d eof=%b", got_rsp, got_code, got_pos, got_eof, e.code, e.pos, e.eof);
        end
        sb.push_back('{CLAMP ? 32'd0 : ERR, 16'd100, 1'b0});
        send_req(SET, 16'd101, 1'b0);
        e = sb.pop_front(); checks++;
        if (!got_rsp || got_code !== e.code || got_pos !== e.pos || got_eof !== e.eof) begin
            errors++; $display("FAIL set_size_plus1: rsp=%b code=%h pos=%0d eof=%b, want code=%h pos=%0d eof=%b", got_rsp, got_code, got_pos, got_eof, e.code, e.pos, e.eof);
        end
    endtask

    task automatic test_end_read_rewind();
        sb.push_back('{32'd0, 16'd99, 1'b0});
        send_req(ENDP, 16'hFFFF, 1'b0);
        e = sb.pop_front(); checks++;
        if (!got_rsp || got_code !== e.code || got_pos !== e.pos || got_eof !== e.eof) begin
            errors++; $display("FAIL end_minus1: rsp=%b code=%h pos=%0d eof=%b, want code=%h pos=%0d eof=%b", got_rsp, got_code, got_pos, got_eof, e.code, e.pos, e.eof);
        end
        pulse(1'b1, 1'b0, 1'b0, 16'd0);
        checks++;
        if (pos !== 16'd100 || eof !== 1'b0) begin
            errors++; $display("FAIL read1: pos=%0d eof=%b, want 100 0", pos, eof);
        end
        pulse(1'b1, 1'b0, 1'b0, 16'd0);
        checks++;
        if (pos !== 16'd100 || eof !== 1'b1) begin
            errors++; $display("FAIL read_at_end: pos=%0d eof=%b, want 100 1", pos, eof);
        end
        sb.push_back('{CLAMP ? 32'd0 : ERR, 16'd100, CLAMP ? 1'b0 : 1'b1});
        send_req(ENDP, 16'd1, 1'b0);
        e = sb.pop_front(); checks++;
        if (!got_rsp || got_code !== e.code || got_pos !== e.pos || got_eof !== e.eof) begin
            errors++; $display("FAIL end_plus1: rsp=%b code=%h pos=%0d eof=%b, want code=%h pos=%0d eof=%b", got_rsp, got_code, got_pos, got_eof, e.code, e.pos, e.eof);
        end
        sb.push_back('{32'd0, 16'd0, 1'b0});
        send_req(REW, 16'h8123, 1'b0);
        e = sb.pop_front(); checks++;
        if (!got_rsp || got_code !== e.code || got_pos !== e.pos || got_eof !== e.eof || lat !== 3) begin
            errors++; $display("FAIL rewind: rsp=%b code=%h pos=%0d eof=%b lat=%0d, want code=%h pos=%0d eof=%b lat=3", got_rsp, got_code, got_pos, got_eof, lat, e.code, e.pos, e.eof);
        end
    endtask

    task automatic test_write();
        sb.push_back('{32'd0, 16'd100, 1'b0});
        send_req(SET, 16'd100, 1'b0);
        e = sb.pop_front(); checks++;
        if (!got_rsp || got_code !== e.code || got_pos !== e.pos) begin
            errors++; $display("FAIL set100: rsp=%b code=%h pos=%0d, want code=%h pos=%0d", got_rsp, got_code, got_pos, e.code, e.pos);
        end
        repeat (3) pulse(1'b1, 1'b1, 1'b0, 16'd0);
        checks++;
        if (pos !== 16'd103 || size !== 16'd103) begin
            errors++; $display("FAIL append3: pos=%0d size=%0d, want 103 103", pos, size);
        end
        pulse(1'b0, 1'b0, 1'b1, 16'd50);
        checks++;
        if (pos !== 16'd50 || size !== 16'd50 || eof !== 1'b0) begin
            errors++; $display("FAIL shrink50: pos=%0d size=%0d eof=%b, want 50 50 0", pos, size, eof);
        end
        sb.push_back('{32'd0, 16'd10, 1'b0});
        send_req(SET, 16'd10, 1'b0);
        e = sb.pop_front();
        pulse(1'b1, 1'b1, 1'b0, 16'd0);
        checks++;
        if (!got_rsp || got_pos !== e.pos || pos !== 16'd11 || size !== 16'd50) begin
            errors++; $display("FAIL overwrite: rsp=%b seek_pos=%0d pos=%0d size=%0d, want seek_pos=%0d pos=11 size=50", got_rsp, got_pos, pos, size, e.pos);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = SET; req_offset = 16'd10;
        @(negedge clk);
        req_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (req_ready !== 1'b1 || pos !== 16'd0 || size !== 16'd0 || eof !== 1'b0) begin
            errors++; $display("FAIL abort_state: ready=%b pos=%0d size=%0d eof=%b, want 1 0 0 0", req_ready, pos, size, eof);
        end
        seen = 0;
        repeat (6) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || pos !== 16'd0) begin
            errors++; $display("FAIL abort_no_rsp: rsp pulses=%0d pos=%0d, want 0 0", seen, pos);
        end
    endtask

    task automatic test_collision();
        pulse(1'b0, 1'b0, 1'b1, 16'd100);
        sb.push_back('{32'd0, 16'd20, 1'b0});
        send_req(SET, 16'd20, 1'b0);
        e = sb.pop_front(); checks++;
        if (!got_rsp || got_pos !== e.pos) begin
            errors++; $display("FAIL set20: rsp=%b pos=%0d, want pos=%0d", got_rsp, got_pos, e.pos);
        end
        sb.push_back('{32'd0, 16'd25, 1'b0});
        send_req(CUR, 16'd5, 1'b1);
        e = sb.pop_front();
        @(negedge clk);
        checks++;
        if (!got_rsp || got_code !== e.code || got_pos !== e.pos || pos !== e.pos || lat !== 3) begin
            errors++; $display("FAIL req_vs_xfer: rsp=%b code=%h pos=%0d later_pos=%0d lat=%0d, want code=%h pos=%0d lat=3", got_rsp, got_code, got_pos, pos, lat, e.code, e.pos);
        end
        pulse(1'b1, 1'b1, 1'b1, 16'd60);
        checks++;
        if (size !== 16'd60 || pos !== 16'd25) begin
            errors++; $display("FAIL load_vs_write: size=%0d pos=%0d, want 60 25", size, pos);
        end
        pulse(1'b1, 1'b0, 1'b0, 16'd0);
        checks++;
        if (pos !== 16'd26 || eof !== 1'b0) begin
            errors++; $display("FAIL read_mid: pos=%0d eof=%b, want 26 0", pos, eof);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_out_of_range();
        test_end_read_rewind();
        test_write();
        test_reset_abort();
        test_collision();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
